mem_stage: RTL
==============

Name: mem_stage

Overview:
- Memory (M) stage of the 5-stage RV32IM pipeline. Sits between the execute stage's EX/MEM register and writeback.
- Issues loads and stores to the data-memory port using a req/gnt/rvalid handshake.
- Aligns and sign-/zero-extends load data and generates store byte enables.
- Stalls the pipeline while an access is outstanding and latches results into the MEM/WB register.

Parameters:
XLEN, 32, data/address width (only 32 supported)

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
stall_w_i  in  1  hazard unit: hold MEM/WB register
flush_m_i  in  1  hazard unit: kill instruction currently in M
ex_valid_i  in  1  EX/MEM entry holds a real instruction
ex_alu_result_i  in  32  ALU result / effective address
ex_store_data_i  in  32  forwarded rs2 data
ex_rd_addr_i  in  5  destination register
ex_reg_write_en_i  in  1  instruction writes rd
ex_mem_read_en_i  in  1  load
ex_mem_write_en_i  in  1  store
ex_funct3_i  in  3  load/store size and sign
dmem_req_o  out  1  access request
dmem_we_o  out  1  1 = store
dmem_addr_o  out  32  word-aligned address ({addr[31:2],2'b00})
dmem_be_o  out  4  byte enables
dmem_wdata_o  out  32  lane-replicated store data
dmem_gnt_i  in  1  request accepted
dmem_rvalid_i  in  1  load data valid
dmem_rdata_i  in  32  load data
mem_stall_req_o  out  1  access not complete this cycle
misaligned_o  out  1  misaligned access detected (combinational)
wb_valid_o  out  1  MEM/WB valid
wb_reg_write_en_o  out  1  MEM/WB write enable
wb_rd_addr_o  out  5  MEM/WB destination
wb_data_o  out  32  MEM/WB result (load data or ALU result)

Behaviour:
- Reset (async, rst_ni=0): FSM=IDLE, kill flag=0, all wb_* outputs=0. dmem_req_o=0 and mem_stall_req_o=0 while in reset.
- A valid access is: ex_valid_i & (mem_read|mem_write) & aligned & !flush_m_i.
- Misalignment rules: halfword requires addr[0]=0; word requires addr[1:0]=0. funct3 011/110/111 are treated as word.
- Misaligned access: misaligned_o=1 the same cycle, no bus request, no stall. The MEM/WB entry is written with reg_write_en=0.
- FSM IDLE:
  - A valid access drives dmem_req_o=1 combinationally.
  - gnt=1 on a store: complete, no stall.
  - gnt=1 on a load: go to RESP, stall=1.
  - gnt=0: go to REQ, stall=1.
- FSM REQ: req held with address, be and wdata stable; the upstream hazard unit holds ex_* stable while stall=1. On gnt, a store completes and goes to IDLE with stall=0 that cycle; a load goes to RESP.
- FSM RESP: req=0. On rvalid, capture the formatted load data into MEM/WB, go to IDLE, stall=0 that cycle. Minimum load latency is 2 cycles (rvalid is never accepted in the gnt cycle).
- mem_stall_req_o = access pending & !(completion this cycle).
- Store formatting:
  - SB: be=4'b0001<<addr[1:0], wdata={4{byte}}.
  - SH: be=addr[1]?1100:0011, wdata={2{half}}.
  - SW: be=1111.
  - Loads drive be=1111 and dmem_we_o=0.
- Load formatting: select lane by addr[1:0].
  - LB/LH sign-extend; LBU/LHU zero-extend.
  - LW passes through.
- Non-memory instructions: wb_data=ex_alu_result_i, completes in 1 cycle.
- MEM/WB register update priority:
  1. reset.
  2. stall_w_i=1: hold all wb_*. An FSM in REQ/RESP still advances; a completed load's data is held internally and written when stall_w_i drops.
  3. mem_stall_req_o=1: insert bubble (wb_valid=0, reg_write_en=0).
  4. Capture: wb_valid=ex_valid & !flush; wb_reg_write_en=ex_reg_write_en & ex_valid & !flush & !misaligned.
- Flush:
  - flush_m_i in IDLE suppresses the request.
  - An issued request is never withdrawn: flush in REQ/RESP sets the kill flag.
  - The access still completes (req held to gnt, rvalid consumed).
  - The result is written as a bubble; kill clears on return to IDLE.
- Stores never wait for rvalid. An rvalid received in IDLE/REQ is ignored.

Test Plan:
- ALU op (alu_result=0x1234, rd=5, reg_write=1), no memory → next edge wb_data=0x1234, wb_rd=5, wb_reg_write_en=1, no stall.
- LB at 0x1003, gnt same cycle, rvalid next cycle, rdata=0x80FF_FFFF → stall=1 for one cycle, dmem_addr=0x1000, wb_data=0xFFFF_FF80. Repeat as LBU → 0x0000_0080.
- SH at 0x2002, data 0xABCD_1234, gnt delayed 3 cycles → req/addr/be stable for 4 cycles, be=1100, wdata=0x1234_1234, stall deasserts in the gnt cycle, wb_reg_write_en=0.
- LW at 0x3001 → misaligned_o=1, dmem_req_o=0, no stall, wb_reg_write_en=0.
- LW issued, flush_m_i asserted in RESP, rvalid after 2 cycles with 0xDEADBEEF → access completes, wb_valid=0, wb_reg_write_en=0, FSM returns to IDLE.
- rst_ni asserted while in RESP → all outputs 0 immediately; after release FSM=IDLE and a new LW completes normally.

Source files
------------

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - RV32IM memory stage: data-memory req/gnt/rvalid access, load/store formatting, MEM/WB register
module mem_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            stall_w_i,
  input  logic            flush_m_i,
  input  logic            ex_valid_i,
  input  logic [XLEN-1:0] ex_alu_result_i,
  input  logic [XLEN-1:0] ex_store_data_i,
  input  logic [4:0]      ex_rd_addr_i,
  input  logic            ex_reg_write_en_i,
  input  logic            ex_mem_read_en_i,
  input  logic            ex_mem_write_en_i,
  input  logic [2:0]      ex_funct3_i,
  output logic            dmem_req_o,
  output logic            dmem_we_o,
  output logic [XLEN-1:0] dmem_addr_o,
  output logic [3:0]      dmem_be_o,
  output logic [XLEN-1:0] dmem_wdata_o,
  input  logic            dmem_gnt_i,
  input  logic            dmem_rvalid_i,
  input  logic [XLEN-1:0] dmem_rdata_i,
  output logic            mem_stall_req_o,
  output logic            misaligned_o,
  output logic            wb_valid_o,
  output logic            wb_reg_write_en_o,
  output logic [4:0]      wb_rd_addr_o,
  output logic [XLEN-1:0] wb_data_o
);
  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

  state_t          state_q, state_d;
  logic            kill_q, kill_d, kill_eff;
  // done_q: access finished while MEM/WB was held; result parked until stall_w_i drops
  logic            done_q, done_kill_q;
  logic [XLEN-1:0] done_data_q;
  logic            is_mem, is_half, is_word, access;
  logic            req, pending, complete, load_done, stall;
  logic [XLEN-1:0] lane, load_data;
  logic [3:0]      store_be;
  logic [XLEN-1:0] store_data;

  assign is_mem  = ex_mem_read_en_i | ex_mem_write_en_i;
  assign is_half = (ex_funct3_i[1:0] == 2'b01);
  assign is_word = ex_funct3_i[1];
  assign misaligned_o = rst_ni & ex_valid_i & is_mem &
                        ((is_half & ex_alu_result_i[0]) | (is_word & (|ex_alu_result_i[1:0])));
  assign access = ex_valid_i & is_mem & ~misaligned_o & ~flush_m_i;

  always_comb begin
    state_d   = state_q;
    req       = 1'b0;
    pending   = 1'b0;
    complete  = 1'b0;
    load_done = 1'b0;
    case (state_q)
      IDLE: begin
        if (access && !done_q) begin
          req     = 1'b1;
          pending = 1'b1;
          if (dmem_gnt_i) begin
            if (ex_mem_write_en_i) complete = 1'b1;
            else                   state_d  = RESP;
          end else begin
            state_d = REQ;
          end
        end
      end
      REQ: begin
        req     = 1'b1;
        pending = 1'b1;
        if (dmem_gnt_i) begin
          if (ex_mem_write_en_i) begin
            complete = 1'b1;
            state_d  = IDLE;
          end else begin
            state_d = RESP;
          end
        end
      end
      RESP: begin
        pending = 1'b1;
        if (dmem_rvalid_i) begin
          complete  = 1'b1;
          load_done = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign stall    = pending & ~complete;
  assign kill_eff = kill_q | (flush_m_i & (state_q != IDLE));
  assign kill_d   = (state_d == IDLE) ? 1'b0 : kill_eff;

  always_comb begin
    store_be   = 4'b1111;
    store_data = ex_store_data_i;
    if (ex_mem_write_en_i) begin
      case (ex_funct3_i[1:0])
        2'b00: begin
          store_be   = 4'b0001 << ex_alu_result_i[1:0];
          store_data = {4{ex_store_data_i[7:0]}};
        end
        2'b01: begin
          store_be   = ex_alu_result_i[1] ? 4'b1100 : 4'b0011;
          store_data = {2{ex_store_data_i[15:0]}};
        end
        default: store_be = 4'b1111;
      endcase
    end
  end

  assign lane = dmem_rdata_i >> {ex_alu_result_i[1:0], 3'b000};
  always_comb begin
    case (ex_funct3_i)
      3'b000:  load_data = {{24{lane[7]}}, lane[7:0]};
      3'b001:  load_data = {{16{lane[15]}}, lane[15:0]};
      3'b100:  load_data = {24'd0, lane[7:0]};
      3'b101:  load_data = {16'd0, lane[15:0]};
      default: load_data = dmem_rdata_i;
    endcase
  end

  assign dmem_req_o      = req & rst_ni;
  assign dmem_we_o       = dmem_req_o & ex_mem_write_en_i;
  assign dmem_addr_o     = dmem_req_o ? {ex_alu_result_i[XLEN-1:2], 2'b00} : '0;
  assign dmem_be_o       = dmem_req_o ? store_be : 4'b0000;
  assign dmem_wdata_o    = dmem_req_o ? store_data : '0;
  assign mem_stall_req_o = stall & rst_ni;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      kill_q      <= 1'b0;
      done_q      <= 1'b0;
      done_kill_q <= 1'b0;
      done_data_q <= '0;
    end else begin
      state_q <= state_d;
      kill_q  <= kill_d;
      if (complete && stall_w_i) begin
        done_q      <= 1'b1;
        done_kill_q <= kill_eff;
        done_data_q <= load_done ? load_data : ex_alu_result_i;
      end else if (done_q && !stall_w_i) begin
        done_q      <= 1'b0;
        done_kill_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wb_valid_o        <= 1'b0;
      wb_reg_write_en_o <= 1'b0;
      wb_rd_addr_o      <= 5'd0;
      wb_data_o         <= '0;
    end else if (stall_w_i) begin
      wb_valid_o        <= wb_valid_o;
    end else if (stall) begin
      wb_valid_o        <= 1'b0;
      wb_reg_write_en_o <= 1'b0;
    end else begin
      wb_valid_o        <= ex_valid_i & ~flush_m_i & ~kill_eff & ~(done_q & done_kill_q);
      wb_reg_write_en_o <= ex_reg_write_en_i & ex_valid_i & ~flush_m_i & ~misaligned_o &
                           ~kill_eff & ~(done_q & done_kill_q);
      wb_rd_addr_o      <= ex_rd_addr_i;
      wb_data_o         <= done_q ? done_data_q : (load_done ? load_data : ex_alu_result_i);
    end
  end
endmodule
